// File: rtl/hub_bcast_sched.sv
// Broadcast read scheduler: walks board_mask lowest-first, issues one read per board and waits for
// its response or a timeout. Optional macro HUB_SCHED_RETRY_EN grants each board one retry.
module hub_bcast_sched #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bcast_seq,
  input  logic [15:0] board_mask,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [3:0]  req_board,
  output logic [15:0] req_seq,
  input  logic        resp_valid,
  input  logic [3:0]  resp_board,
  input  logic [15:0] resp_seq,
  output logic        busy,
  output logic        done,
  output logic [15:0] resp_mask,
  output logic [15:0] tmo_mask
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;

  localparam logic [15:0] TMO_LAST = TIMEOUT_CYCLES - 16'd1;

  state_t      state, state_nxt;
  logic [15:0] pending, pending_nxt;
  logic [3:0]  board_nxt;
  logic [15:0] seq_nxt;
  logic [15:0] timer, timer_nxt;
  logic [15:0] resp_nxt, tmo_nxt;
  logic [15:0] remain;
  logic        match;
`ifdef HUB_SCHED_RETRY_EN
  logic        retried, retried_nxt;
`endif

  function automatic logic [3:0] lowest_set(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (m[i]) idx = 4'(i);
    return idx;
  endfunction

  assign match     = resp_valid && (resp_board == req_board) && (resp_seq == req_seq);
  assign remain    = pending & ~(16'd1 << req_board);
  assign req_valid = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    board_nxt   = req_board;
    seq_nxt     = req_seq;
    timer_nxt   = timer;
    resp_nxt    = resp_mask;
    tmo_nxt     = tmo_mask;
`ifdef HUB_SCHED_RETRY_EN
    retried_nxt = retried;
`endif
    // A start pulse restarts from scratch regardless of the current state.
    if (start) begin
      seq_nxt     = bcast_seq;
      pending_nxt = board_mask;
      board_nxt   = lowest_set(board_mask);
      resp_nxt    = 16'd0;
      tmo_nxt     = 16'd0;
      timer_nxt   = 16'd0;
`ifdef HUB_SCHED_RETRY_EN
      retried_nxt = 1'b0;
`endif
      state_nxt   = (board_mask != 16'd0) ? ISSUE : DONE;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        ISSUE: begin
          if (req_ready) begin
            timer_nxt = 16'd0;
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          // A response landing on the expiry cycle still counts as answered.
          if (match) begin
            resp_nxt[req_board] = 1'b1;
            state_nxt           = NEXT;
          end else if (timer == TMO_LAST) begin
`ifdef HUB_SCHED_RETRY_EN
            if (!retried) begin
              retried_nxt = 1'b1;
              timer_nxt   = 16'd0;
              state_nxt   = ISSUE;
            end else begin
              tmo_nxt[req_board] = 1'b1;
              state_nxt          = NEXT;
            end
`else
            tmo_nxt[req_board] = 1'b1;
            state_nxt          = NEXT;
`endif
          end else begin
            timer_nxt = timer + 16'd1;
          end
        end
        NEXT: begin
          pending_nxt = remain;
`ifdef HUB_SCHED_RETRY_EN
          retried_nxt = 1'b0;
`endif
          if (remain != 16'd0) begin
            board_nxt = lowest_set(remain);
            state_nxt = ISSUE;
          end else begin
            state_nxt = DONE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pending   <= 16'd0;
      req_board <= 4'd0;
      req_seq   <= 16'd0;
      timer     <= 16'd0;
      resp_mask <= 16'd0;
      tmo_mask  <= 16'd0;
`ifdef HUB_SCHED_RETRY_EN
      retried   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      req_board <= board_nxt;
      req_seq   <= seq_nxt;
      timer     <= timer_nxt;
      resp_mask <= resp_nxt;
      tmo_mask  <= tmo_nxt;
`ifdef HUB_SCHED_RETRY_EN
      retried   <= retried_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_hub_bcast_sched.sv
// Bench for hub_bcast_sched: a request/mask scoreboard derived from each board's response plan,
// compared every cycle, plus directed latency and boundary checks. Follows HUB_SCHED_RETRY_EN.
module tb_hub_bcast_sched;
  localparam int T = 10;
`ifdef HUB_SCHED_RETRY_EN
  localparam int TRIES   = 2;
  localparam int TMO_LAT = 23;
`else
  localparam int TRIES   = 1;
  localparam int TMO_LAT = 12;
`endif

  logic        sysclk = 1'b0;
  logic        reset, start, req_ready, resp_valid;
  logic [15:0] bcast_seq, board_mask, resp_seq;
  logic [3:0]  resp_board;
  logic        req_valid, busy, done;
  logic [3:0]  req_board;
  logic [15:0] req_seq, resp_mask, tmo_mask;

  hub_bcast_sched #(.TIMEOUT_CYCLES(16'd10)) dut (
    .sysclk(sysclk), .reset(reset), .start(start), .bcast_seq(bcast_seq),
    .board_mask(board_mask), .req_valid(req_valid), .req_ready(req_ready),
    .req_board(req_board), .req_seq(req_seq), .resp_valid(resp_valid),
    .resp_board(resp_board), .resp_seq(resp_seq), .busy(busy), .done(done),
    .resp_mask(resp_mask), .tmo_mask(tmo_mask)
  );

  initial forever #5 sysclk = ~sysclk;

  int checks = 0, passed = 0, done_cnt = 0;
  int exp_q[$];
  logic [15:0] exp_seq = 16'd0, exp_resp = 16'd0, exp_tmo = 16'd0;
  int good_k[16], bad_k[16];
  logic [3:0]  bad_bx[16];
  logic [15:0] bad_sx[16];
  int stray_want = 0, stray_used = 0;
  int rj = 0;
  bit ract = 1'b0;
  logic [3:0]  rb = 4'd0;
  logic [15:0] rs = 16'd0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endfunction

  // Expected request sequence and final masks from each board's response delay:
  // a response k edges after acceptance is seen only when 1 <= k <= T.
  task automatic load_model(input logic [15:0] s, input logic [15:0] m);
    exp_q.delete();
    exp_seq = s; exp_resp = 16'd0; exp_tmo = 16'd0;
    for (int b = 0; b < 16; b++) begin
      if (m[b]) begin
        if (good_k[b] >= 1 && good_k[b] <= T) begin
          exp_q.push_back(b);
          exp_resp[b] = 1'b1;
        end else begin
          for (int t = 0; t < TRIES; t++) exp_q.push_back(b);
          exp_tmo[b] = 1'b1;
        end
      end
    end
  endtask

  task automatic clear_plan();
    for (int b = 0; b < 16; b++) begin
      good_k[b] = 0; bad_k[b] = 0; bad_bx[b] = 4'd0; bad_sx[b] = 16'd0;
    end
  endtask

  task automatic compare_cycle();
    if (!reset) begin
      chk("reset_ctl", {req_valid, busy, done, req_board}, 32'd0);
      chk("reset_seq", req_seq, 32'd0);
      chk("reset_masks", {resp_mask, tmo_mask}, 32'd0);
    end else begin
      if (req_valid) begin
        chk("req_busy", busy, 32'd1);
        if (exp_q.size() == 0) chk("req_unexpected", req_valid, 32'd0);
        else begin
          chk("req_board", req_board, exp_q[0]);
          chk("req_seq", req_seq, exp_seq);
          if (req_ready) void'(exp_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_resp_mask", resp_mask, exp_resp);
        chk("done_tmo_mask", tmo_mask, exp_tmo);
        chk("done_reqs_left", exp_q.size(), 32'd0);
      end
    end
  endtask

  task automatic respond_cycle();
    resp_valid = 1'b0;
    rj++;
    if (ract && rj == bad_k[rb]) begin
      resp_valid = 1'b1; resp_board = rb ^ bad_bx[rb]; resp_seq = rs ^ bad_sx[rb];
    end
    if (ract && rj == good_k[rb]) begin
      resp_valid = 1'b1; resp_board = rb; resp_seq = rs; ract = 1'b0;
    end
    if (stray_want > stray_used && req_valid && !req_ready) begin
      resp_valid = 1'b1; resp_board = req_board; resp_seq = req_seq; stray_used++;
    end
    if (!reset) ract = 1'b0;
    else if (req_valid && req_ready) begin
      ract = 1'b1; rj = 0; rb = req_board; rs = req_seq;
    end
  endtask

  task automatic tick();
    @(negedge sysclk);
    compare_cycle();
    respond_cycle();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] s, input logic [15:0] m);
    start = 1'b1; bcast_seq = s; board_mask = m;
    tick();
    start = 1'b0;
    load_model(s, m);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    tick();
  endtask

  initial begin
    int lat, dc;
    reset = 1'b0; start = 1'b0; bcast_seq = 16'd0; board_mask = 16'd0; req_ready = 1'b1;
    resp_valid = 1'b0; resp_board = 4'd0; resp_seq = 16'd0;
    clear_plan();
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Two boards answered after three edges each.
    good_k[0] = 3; good_k[5] = 3;
    do_start(16'h1234, 16'h0021);
    wait_done(lat);
    chk("t1_latency", lat, 32'd10);
    repeat (3) tick();
    chk("t1_hold_resp", resp_mask, 32'h0021);
    chk("t1_hold_tmo", tmo_mask, 32'h0000);
    chk("t1_idle", {busy, done, req_valid}, 32'd0);

    // Silent board times out.
    clear_plan();
    do_start(16'h0002, 16'h0004);
    chk("t2_start_clears", {resp_mask, tmo_mask}, 32'd0);
    wait_done(lat);
    chk("t2_latency", lat, TMO_LAT);
    chk("t2_tmo_mask", tmo_mask, 32'h0004);

    // Empty mask completes at once.
    do_start(16'h0003, 16'h0000);
    chk("t3_busy_first", busy, 32'd1);
    wait_done(lat);
    chk("t3_latency", lat, 32'd0);
    chk("t3_busy_after", {busy, done}, 32'd0);

    // Wrong sequence number ignored before the real response.
    clear_plan();
    good_k[0] = 5; bad_k[0] = 2; bad_sx[0] = 16'h0001; good_k[15] = 1;
    do_start(16'hBEEF, 16'h8001);
    lat = 0;
    while (!resp_mask[0] && lat < 50) begin
      tick();
      lat++;
    end
    chk("t4_bit0_latency", lat, 32'd6);
    wait_done(lat);
    chk("t4_resp_mask", resp_mask, 32'h8001);

    // Response on the expiry edge wins; one edge later is too late.
    clear_plan();
    good_k[3] = T; good_k[4] = T + 1;
    do_start(16'h4321, 16'h0018);
    wait_done(lat);
    chk("t5_resp_mask", resp_mask, 32'h0008);
    chk("t5_tmo_mask", tmo_mask, 32'h0010);

    // Restart mid-wait: the aborted cycle produces no done.
    clear_plan();
    dc = done_cnt;
    do_start(16'h0055, 16'h00F0);
    repeat (4) tick();
    good_k[1] = 2;
    do_start(16'h0066, 16'h0002);
    wait_done(lat);
    chk("t6_one_done", done_cnt - dc, 32'd1);
    chk("t6_resp_mask", resp_mask, 32'h0002);

    // Responses outside WAIT or for another board never set a mask.
    clear_plan();
    req_ready = 1'b0;
    stray_want = stray_used + 1;
    bad_k[6] = 1; bad_bx[6] = 4'h1;
    do_start(16'h0777, 16'h0040);
    repeat (3) tick();
    chk("t8_stray_sent", stray_used, stray_want);
    req_ready = 1'b1;
    wait_done(lat);
    chk("t8_resp_mask", resp_mask, 32'h0000);
    chk("t8_tmo_mask", tmo_mask, 32'h0040);

    // Asynchronous reset mid-wait.
    clear_plan();
    dc = done_cnt;
    do_start(16'h0ABC, 16'h0003);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    chk("t7_rst_ctl", {req_valid, busy, done, req_board}, 32'd0);
    chk("t7_rst_seq", req_seq, 32'd0);
    chk("t7_rst_masks", {resp_mask, tmo_mask}, 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    repeat (T + 5) tick();
    chk("t7_no_done", done_cnt - dc, 32'd0);
    chk("t7_idle", busy, 32'd0);

    chk("total_dones", done_cnt, 32'd7);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/hub_bcast_sched.md
# hub_bcast_sched

Broadcast read scheduler for the hub. On a broadcast request (the hub register write carrying `sequence`/`board_mask`) it walks the board mask lowest-first and issues one read request per selected board to the packet transmitter via a valid/ready handshake. It then waits for that board's response to land in hub memory, or for a per-board timeout. It publishes which boards answered and which timed out, so the host reads only valid hub memory entries and learns of missing boards without polling. It sits between the hub register block and the FireWire transmit engine.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16'd2000: sysclk cycles to wait for one board's response after request acceptance; legal 2..65535.

Ports:
- `sysclk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse (hub register write) starting a broadcast cycle
- `sequence`  in  16  sequence number for this cycle; sampled with `start`
- `board_mask`  in  16  selected boards; sampled with `start`
- `req_valid`  out  1  read request pending to transmitter
- `req_ready`  in  1  transmitter accepts request
- `req_board`  out  4  board number of current request
- `req_seq`  out  16  latched sequence number
- `resp_valid`  in  1  one-cycle pulse: response written to hub memory
- `resp_board`  in  4  board number of response
- `resp_seq`  in  16  sequence number of response
- `busy`  out  1  cycle in progress
- `done`  out  1  one-cycle pulse at cycle end
- `resp_mask`  out  16  boards that answered this cycle
- `tmo_mask`  out  16  boards that timed out this cycle

## Operation
- States: IDLE, ISSUE, WAIT, NEXT, DONE.
- IDLE: on `start`, latch `sequence` to `req_seq` and `board_mask` to internal `pending`. Clear `resp_mask`/`tmo_mask`. If mask nonzero: `req_board` = lowest set bit of mask, go to ISSUE. If mask zero, go to DONE.
- ISSUE: `req_valid`=1; hold `req_board`/`req_seq` stable until `req_valid && req_ready`, then WAIT with timer cleared. No timeout in ISSUE.
- WAIT: timer increments each cycle.
  - Match when `resp_valid && resp_board==req_board && resp_seq==req_seq`: set `resp_mask[req_board]`, go to NEXT.
  - When timer reaches `TIMEOUT_CYCLES-1` with no match: set `tmo_mask[req_board]`, go to NEXT.
- NEXT: clear `pending[req_board]`. If the remainder is nonzero, load its lowest set bit into `req_board` and go to ISSUE. Otherwise go to DONE.
- DONE: `done`=1 for exactly this cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- Non-matching `resp_valid` is ignored and never alters masks: wrong board, wrong seq, or any state other than WAIT.
- `start` while busy: abort the current cycle and restart with the new values, exactly as from IDLE. Any in-flight request is dropped (`req_valid` may fall before ready). No `done` is issued for the aborted cycle.
- Board index arithmetic is 4-bit. The lowest-set-bit search is combinational over 16 bits; no wrap, each board is visited at most once per cycle.

## Timing
- Reset values: `req_valid`=0, `req_board`=0, `req_seq`=0, `busy`=0, `done`=0, `resp_mask`=0, `tmo_mask`=0, state IDLE, timer 0.
- `start` sampled at edge N → `busy`/`req_valid` high from cycle N+1.
- Request accepted at edge A → WAIT from A+1. A match at edge R → NEXT at R+1, ISSUE of the next board at R+2 (or DONE at R+2).
- Timeout: no match → WAIT occupies exactly `TIMEOUT_CYCLES` cycles.
- A match in the same cycle the timer expires: response wins (`resp_mask` set, `tmo_mask` not).
- Masks update at the NEXT transition and hold stable from `done` until the next `start`.
- Mask zero: `done` at cycle N+1, `busy` high only that cycle.
- Reset asserted mid-cycle: immediate return to reset values, no `done`.

## Configuration
- `HUB_SCHED_RETRY_EN`:
  - Defined: on first timeout for a board, return to ISSUE for the same board (one retry, timer cleared). Only a second timeout sets `tmo_mask`.
  - Undefined: no retry; the first timeout is final.

## Test plan
- `start`, seq=0x1234, mask=0x0021, `req_ready` tied 1, responses (0,0x1234) and (5,0x1234) 3 cycles after each accept → `req_board` 0 then 5, `done` once, `resp_mask`=0x0021, `tmo_mask`=0.
- mask=0x0004, no response, `TIMEOUT_CYCLES`=10 → WAIT exactly 10 cycles, `tmo_mask`=0x0004. With `HUB_SCHED_RETRY_EN`: two requests for board 2, 20 WAIT cycles total.
- mask=0x0000 → `done` at N+1, both masks 0, `req_valid` never high.
- mask=0x8001, response for board 0 with seq off by one, then correct → first ignored, `resp_mask` bit 0 set only after the second.
- Response on the exact timer-expiry cycle → `resp_mask` bit set, `tmo_mask` clear.
- `start` mask=0x00F0, restart after board 4 accepted with mask=0x0002 → no `done` for the first cycle, final `resp_mask`⊆0x0002; reset pulse mid-WAIT → all outputs return to 0.
